// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access, one transaction at a time.
// Optional ARB_RR_EN: round-robin between channels on simultaneous requests (default: data priority).
module sram_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              imem_busy,
    output logic              dmem_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              i_out_q, i_out_d;
    logic              d_out_q, d_out_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              win_c;

`ifdef ARB_RR_EN
    logic              last_gnt_q, last_gnt_d;

    // On contention the channel not granted last time wins.
    always_comb begin
        if (i_req && d_req) begin
            win_c = ~last_gnt_q;
        end else begin
            win_c = d_req;
        end
    end
`else
    // Data channel wins whenever it requests.
    always_comb begin
        win_c = d_req;
    end
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        i_out_d   = i_out_q;
        d_out_d   = d_out_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef ARB_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        m_req     = 1'b0;
        m_wr      = 1'b0;
        m_size    = 2'd2;
        m_addr    = '0;
        m_wdata   = '0;
        i_addr_ok = 1'b0;
        d_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        d_data_ok = 1'b0;
        i_rdata   = i_rdata_q;
        d_rdata   = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    gnt_d   = win_c;
                    state_d = ST_ADDR;
`ifdef ARB_RR_EN
                    last_gnt_d = win_c;
`endif
                end
            end
            ST_ADDR: begin
                m_req = 1'b1;
                if (gnt_q) begin
                    m_wr    = d_wr;
                    m_size  = d_size;
                    m_addr  = d_addr;
                    m_wdata = d_wdata;
                end else begin
                    m_addr  = i_addr;
                end
                if (m_addr_ok) begin
                    state_d = ST_DATA;
                    if (gnt_q) begin
                        d_addr_ok = 1'b1;
                        d_out_d   = 1'b1;
                    end else begin
                        i_addr_ok = 1'b1;
                        i_out_d   = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (m_data_ok) begin
                    state_d = ST_IDLE;
                    if (gnt_q) begin
                        d_data_ok = 1'b1;
                        d_rdata   = m_rdata;
                        d_rdata_d = m_rdata;
                        d_out_d   = 1'b0;
                    end else begin
                        i_data_ok = 1'b1;
                        i_rdata   = m_rdata;
                        i_rdata_d = m_rdata;
                        i_out_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset abandons any transaction: silence every handshake and the downstream request.
        if (rst) begin
            m_req     = 1'b0;
            m_wr      = 1'b0;
            m_size    = 2'd2;
            m_addr    = '0;
            m_wdata   = '0;
            i_addr_ok = 1'b0;
            d_addr_ok = 1'b0;
            i_data_ok = 1'b0;
            d_data_ok = 1'b0;
            i_rdata   = '0;
            d_rdata   = '0;
        end
    end

    assign imem_busy = ~rst & (i_req | i_out_q) & ~i_data_ok;
    assign dmem_busy = ~rst & (d_req | d_out_q) & ~d_data_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 1'b0;
            i_out_q   <= 1'b0;
            d_out_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef ARB_RR_EN
            last_gnt_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            i_out_q   <= i_out_d;
            d_out_q   <= d_out_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef ARB_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed test-plan steps followed by randomized traffic
// checked against a transaction-level model of the arbiter.
module tb_sram_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_addr_ok, i_data_ok;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_wr;
    logic [1:0]    d_size;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_addr_ok, d_data_ok;
    logic [DW-1:0] d_rdata;
    logic          m_req, m_wr;
    logic [1:0]    m_size;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_addr_ok, m_data_ok;
    logic [DW-1:0] m_rdata;
    logic          imem_busy, dmem_busy;

    int checks = 0;
    int errors = 0;

    // Model: owner of the bus (-1 none, 0 inst, 1 data), whether its address was accepted,
    // last granted channel, and the last read data delivered to each channel.
    int            mdl_owner;
    bit            mdl_accepted;
    bit            mdl_last;
    logic [DW-1:0] mdl_irdata, mdl_drdata;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Let combinational outputs settle, compare against the model, then advance the model one cycle.
    task automatic eval();
        bit in_addr, in_data, e_iaok, e_daok, e_idok, e_ddok;
        int w;
        #1;
        if (rst) begin
            chk("rst_m_req", m_req, 0);
            chk("rst_i_addr_ok", i_addr_ok, 0);
            chk("rst_d_addr_ok", d_addr_ok, 0);
            chk("rst_i_data_ok", i_data_ok, 0);
            chk("rst_d_data_ok", d_data_ok, 0);
            chk("rst_i_rdata", i_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
            chk("rst_imem_busy", imem_busy, 0);
            chk("rst_dmem_busy", dmem_busy, 0);
            mdl_owner    = -1;
            mdl_accepted = 0;
            mdl_last     = 0;
            mdl_irdata   = '0;
            mdl_drdata   = '0;
        end else begin
            in_addr = (mdl_owner != -1) && !mdl_accepted;
            in_data = (mdl_owner != -1) && mdl_accepted;
            e_iaok  = in_addr && mdl_owner == 0 && m_addr_ok;
            e_daok  = in_addr && mdl_owner == 1 && m_addr_ok;
            e_idok  = in_data && mdl_owner == 0 && m_data_ok;
            e_ddok  = in_data && mdl_owner == 1 && m_data_ok;
            if (e_idok) mdl_irdata = m_rdata;
            if (e_ddok) mdl_drdata = m_rdata;
            chk("m_req", m_req, in_addr);
            if (in_addr && mdl_owner == 1) begin
                chk("m_wr_d", m_wr, d_wr);
                chk("m_size_d", m_size, d_size);
                chk("m_addr_d", m_addr, d_addr);
                chk("m_wdata_d", m_wdata, d_wdata);
            end else if (in_addr) begin
                chk("m_wr_i", m_wr, 0);
                chk("m_size_i", m_size, 2);
                chk("m_addr_i", m_addr, i_addr);
                chk("m_wdata_i", m_wdata, 0);
            end
            chk("i_addr_ok", i_addr_ok, e_iaok);
            chk("d_addr_ok", d_addr_ok, e_daok);
            chk("i_data_ok", i_data_ok, e_idok);
            chk("d_data_ok", d_data_ok, e_ddok);
            chk("i_rdata", i_rdata, mdl_irdata);
            chk("d_rdata", d_rdata, mdl_drdata);
            chk("imem_busy", imem_busy, (i_req || (mdl_owner == 0 && mdl_accepted)) && !e_idok);
            chk("dmem_busy", dmem_busy, (d_req || (mdl_owner == 1 && mdl_accepted)) && !e_ddok);
            if (mdl_owner == -1) begin
                if (i_req || d_req) begin
`ifdef ARB_RR_EN
                    if (i_req && d_req) w = mdl_last ? 0 : 1;
                    else                w = d_req ? 1 : 0;
`else
                    w = d_req ? 1 : 0;
`endif
                    mdl_last     = (w == 1);
                    mdl_owner    = w;
                    mdl_accepted = 0;
                end
            end else if (!mdl_accepted) begin
                if (m_addr_ok) mdl_accepted = 1;
            end else if (m_data_ok) begin
                mdl_owner = -1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        eval();
        tick();
    endtask

    initial begin
        int grants[$];
        bit ia, da;

        rst = 1; i_req = 0; i_addr = '0; d_req = 0; d_wr = 0; d_size = 2'd2;
        d_addr = '0; d_wdata = '0; m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
        cyc(); cyc();
        rst = 0;
        cyc();

        // Single instruction read
        i_req = 1; i_addr = 32'hBFC0_0000;
        eval(); chk("t1_busy_idle", imem_busy, 1); tick();
        cyc();
        m_addr_ok = 1;
        eval(); chk("t1_i_addr_ok", i_addr_ok, 1); tick();
        i_req = 0; m_addr_ok = 0;
        eval(); chk("t1_busy_wait", imem_busy, 1); tick();
        m_data_ok = 1; m_rdata = 32'h3C1D_8000;
        eval();
        chk("t1_i_data_ok", i_data_ok, 1);
        chk("t1_i_rdata", i_rdata, 32'h3C1D_8000);
        chk("t1_busy_done", imem_busy, 0);
        tick();
        m_data_ok = 0; m_rdata = 32'h5555_AAAA;
        eval(); chk("t1_rdata_hold", i_rdata, 32'h3C1D_8000); tick();

        // Simultaneous requests: data first, inst after one idle cycle
        i_req = 1; i_addr = 32'hBFC0_0004;
        d_req = 1; d_wr = 0; d_size = 2'd2; d_addr = 32'h8000_1000;
        cyc();
        m_addr_ok = 1;
        eval();
        chk("t2_d_addr_ok", d_addr_ok, 1);
        chk("t2_i_addr_ok", i_addr_ok, 0);
        chk("t2_m_addr", m_addr, 32'h8000_1000);
        tick();
        d_req = 0; m_addr_ok = 0;
        m_data_ok = 1; m_rdata = 32'h1234_5678;
        eval();
        chk("t2_d_data_ok", d_data_ok, 1);
        chk("t2_d_rdata", d_rdata, 32'h1234_5678);
        chk("t2_imem_busy", imem_busy, 1);
        tick();
        m_data_ok = 0;
        eval(); chk("t2_idle_gap", m_req, 0); chk("t2_busy_gap", imem_busy, 1); tick();
        m_addr_ok = 1;
        eval(); chk("t2_i_addr_ok2", i_addr_ok, 1); chk("t2_m_addr2", m_addr, 32'hBFC0_0004); tick();
        i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h0000_0042;
        eval(); chk("t2_i_data_ok", i_data_ok, 1); tick();
        m_data_ok = 0;

        // Data byte write
        d_req = 1; d_wr = 1; d_size = 2'd0; d_addr = 32'h8000_0003; d_wdata = 32'h0000_00AB;
        cyc();
        m_addr_ok = 1;
        eval();
        chk("t3_m_wr", m_wr, 1);
        chk("t3_m_size", m_size, 0);
        chk("t3_m_addr", m_addr, 32'h8000_0003);
        chk("t3_m_wdata", m_wdata, 32'h0000_00AB);
        tick();
        d_req = 0; m_addr_ok = 0; m_data_ok = 1;
        eval(); chk("t3_d_data_ok", d_data_ok, 1); chk("t3_i_data_ok", i_data_ok, 0); tick();
        m_data_ok = 0;

        // Back-pressure on the address phase, then reset during the data phase
        d_req = 1; d_wr = 0; d_size = 2'd1; d_addr = 32'h8000_2002;
        cyc();
        for (int k = 0; k < 5; k++) begin
            eval();
            chk("t4_m_req", m_req, 1);
            chk("t4_m_addr", m_addr, 32'h8000_2002);
            chk("t4_d_addr_ok", d_addr_ok, 0);
            chk("t4_dmem_busy", dmem_busy, 1);
            tick();
        end
        m_addr_ok = 1;
        cyc();
        d_req = 0; m_addr_ok = 0;
        rst = 1; m_data_ok = 1;
        eval(); chk("t5_rst_d_data_ok", d_data_ok, 0); tick();
        rst = 0;
        eval();
        chk("t5_late_d_data_ok", d_data_ok, 0);
        chk("t5_late_m_req", m_req, 0);
        chk("t5_late_busy", dmem_busy, 0);
        tick();
        m_data_ok = 0;

        // Continuous contention from both channels after a fresh reset
        rst = 1; cyc(); rst = 0;
        i_req = 1; i_addr = 32'hBFC0_0100; d_req = 1; d_wr = 0; d_size = 2'd2; d_addr = 32'h8000_3000;
        m_addr_ok = 1; m_data_ok = 1;
        for (int k = 0; k < 12; k++) begin
            eval();
            if (d_addr_ok) grants.push_back(1);
            if (i_addr_ok) grants.push_back(0);
            tick();
        end
        i_req = 0; d_req = 0; m_addr_ok = 0; m_data_ok = 0;
        chk("t6_grant_count", grants.size(), 4);
        if (grants.size() >= 3) begin
`ifdef ARB_RR_EN
            chk("t6_grant0", grants[0], 1);
            chk("t6_grant1", grants[1], 0);
            chk("t6_grant2", grants[2], 1);
`else
            chk("t6_grant0", grants[0], 1);
            chk("t6_grant1", grants[1], 1);
            chk("t6_grant2", grants[2], 1);
`endif
        end
        cyc(); cyc();

        // Randomized traffic against the model
        ia = 0; da = 0;
        for (int k = 0; k < 800; k++) begin
            if (ia) i_req = 0;
            if (da) d_req = 0;
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_wr = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
                d_addr = $urandom; d_wdata = $urandom;
            end
            m_addr_ok = ($urandom_range(0, 2) == 0);
            m_data_ok = ($urandom_range(0, 2) == 0);
            m_rdata   = $urandom;
            rst       = ($urandom_range(0, 79) == 0);
            eval();
            ia = i_addr_ok;
            da = d_addr_ok;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
